// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_pkg
//  Purpose  : Shared types and constants for the I2C target block.
//  Revision : 1.0  initial release
// ============================================================================
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;

    // Bit counter value reached once a full byte has been shifted.
    localparam logic [3:0] BIT_LAST = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX        = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX        = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } TGT_STATES_t;

endpackage
`default_nettype wire

// File: rtl/i2c_pin_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_pin_sync
//  Purpose  : Synchroniser chain plus history flop and edge detect for one
//             bus line. Idle-high lines, so everything resets to 1.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Move the raw pin through the synchroniser and keep the previous level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q[0] <= pin_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule
`default_nettype wire

// File: rtl/i2c_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_target
//  Purpose  : 7-bit address I2C target with one-byte rx/tx buffering.
//             SDA is driven only after a detected SCL falling edge; SCL is
//             never stretched.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_target
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [I2C_ADDR_W-1:0] ownAddr,
    input  logic                  rxAckEn,
    input  logic [7:0]            txBuffer,
    output logic                  txLoad,
    output logic [7:0]            rxBuffer,
    output logic                  rxValid,
    output logic                  busy,
    output logic                  addressed,
    output logic                  readMode,
    output logic                  nack,
    input  logic                  I2C_SDA_i,
    input  logic                  I2C_SCL_i,
    output logic                  I2C_SDA_o,
    output logic                  I2C_SCL_o
);

    logic sdaLevel, sdaRise, sdaFall;
    logic sclLevel, sclRise, sclFall;
    logic startDet, stopDet;

    TGT_STATES_t state_q;
    logic [3:0]  bitCnt_q;
    logic [7:0]  shift_q;
    logic        sdaOut_q;
    logic        addressed_q;
    logic        readMode_q;
    logic        nack_q;
    logic [7:0]  rxBuffer_q;
    logic        rxValid_q;
    logic        txLoad_q;

    i2c_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (I2C_SDA_i),
        .level_o (sdaLevel),
        .rise_o  (sdaRise),
        .fall_o  (sdaFall)
    );

    i2c_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (I2C_SCL_i),
        .level_o (sclLevel),
        .rise_o  (sclRise),
        .fall_o  (sclFall)
    );

    assign startDet = sdaFall & sclLevel;
    assign stopDet  = sdaRise & sclLevel;

    // Protocol FSM: bus conditions first, then SCL rising (sample), then SCL falling (drive)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            sdaOut_q    <= 1'b1;
            addressed_q <= 1'b0;
            readMode_q  <= 1'b0;
            nack_q      <= 1'b0;
            rxBuffer_q  <= '0;
            rxValid_q   <= 1'b0;
            txLoad_q    <= 1'b0;
        end else begin
            rxValid_q <= 1'b0;
            txLoad_q  <= 1'b0;
            if (!enable) begin
                state_q     <= ST_IDLE;
                sdaOut_q    <= 1'b1;
                addressed_q <= 1'b0;
            end else if (startDet) begin
                state_q  <= ST_ADDR;
                bitCnt_q <= '0;
                sdaOut_q <= 1'b1;
            end else if (stopDet) begin
                state_q     <= ST_IDLE;
                sdaOut_q    <= 1'b1;
                addressed_q <= 1'b0;
            end else if (sclRise) begin
                case (state_q)
                    ST_ADDR, ST_RX: begin
                        if (bitCnt_q != BIT_LAST) begin
                            shift_q  <= {shift_q[6:0], sdaLevel};
                            bitCnt_q <= bitCnt_q + 4'd1;
                        end
                    end
                    ST_TX_ACK: begin
                        if (sdaLevel) begin
                            nack_q  <= 1'b1;
                            state_q <= ST_WAIT_STOP;
                        end else begin
                            state_q  <= ST_TX;
                            bitCnt_q <= '0;
                        end
                    end
                    default: ;
                endcase
            end else if (sclFall) begin
                case (state_q)
                    ST_ADDR: begin
                        if (bitCnt_q == BIT_LAST) begin
                            bitCnt_q <= '0;
                            if (shift_q[7:1] == ownAddr) begin
                                state_q     <= ST_ADDR_ACK;
                                addressed_q <= 1'b1;
                                readMode_q  <= shift_q[0];
                                nack_q      <= 1'b0;
                                sdaOut_q    <= 1'b0;
                            end else begin
                                state_q  <= ST_WAIT_STOP;
                                sdaOut_q <= 1'b1;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (readMode_q) begin
                            state_q  <= ST_TX;
                            shift_q  <= {txBuffer[6:0], 1'b0};
                            sdaOut_q <= txBuffer[7];
                            txLoad_q <= 1'b1;
                            bitCnt_q <= 4'd1;
                        end else begin
                            state_q  <= ST_RX;
                            sdaOut_q <= 1'b1;
                            bitCnt_q <= '0;
                        end
                    end
                    ST_RX: begin
                        if (bitCnt_q == BIT_LAST) begin
                            state_q    <= ST_RX_ACK;
                            rxBuffer_q <= shift_q;
                            rxValid_q  <= 1'b1;
                            sdaOut_q   <= ~rxAckEn;
                        end
                    end
                    ST_RX_ACK: begin
                        // SDA held low during the 9th clock means the byte was ACKed
                        state_q  <= sdaOut_q ? ST_WAIT_STOP : ST_RX;
                        sdaOut_q <= 1'b1;
                        bitCnt_q <= '0;
                    end
                    ST_TX: begin
                        if (bitCnt_q == 4'd0) begin
                            shift_q  <= {txBuffer[6:0], 1'b0};
                            sdaOut_q <= txBuffer[7];
                            txLoad_q <= 1'b1;
                            bitCnt_q <= 4'd1;
                        end else if (bitCnt_q == BIT_LAST) begin
                            state_q  <= ST_TX_ACK;
                            sdaOut_q <= 1'b1;
                        end else begin
                            sdaOut_q <= shift_q[7];
                            shift_q  <= {shift_q[6:0], 1'b0};
                            bitCnt_q <= bitCnt_q + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign I2C_SDA_o = sdaOut_q;
    assign I2C_SCL_o = 1'b1;
    assign rxBuffer  = rxBuffer_q;
    assign rxValid   = rxValid_q;
    assign txLoad    = txLoad_q;
    assign busy      = (state_q != ST_IDLE);
    assign addressed = addressed_q;
    assign readMode  = readMode_q;
    assign nack      = nack_q;

endmodule
`default_nettype wire
